// File: rtl/sdft_pkg.sv
// Shared types for the sliding-DFT post-processing stages: complex sample
// layout, block framing state, per-bin sideband flags and the power width.
package sdft_pkg;

   localparam int CPLX_OW = 32;

   typedef struct packed {
      logic signed [CPLX_OW-1:0] im;
      logic signed [CPLX_OW-1:0] re;
   } cplx_t;

   typedef enum logic {
      IDLE = 1'b0,
      OPEN = 1'b1
   } blk_state_t;

   // Framing decisions travel with each bin so the search stage needs no
   // knowledge of the block state machine.
   typedef struct packed {
      logic first;
      logic in_rng;
      logic good;
      logic err;
   } bin_sb_t;

   function automatic int pw_of(input int ow);
      return 2 * ow;
   endfunction

endpackage

// File: rtl/sdft_peak_finder_cplx_power.sv
// Two-stage |X|^2 pipeline: squares of re/im, then their unsigned sum.
// A valid flag and an opaque user sideband ride along with the data.
module cplx_power
   import sdft_pkg::*;
#(
   parameter int OW = 32,
   parameter int PW = pw_of(OW),
   parameter int UW = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic signed [OW-1:0] re_i,
   input  logic signed [OW-1:0] im_i,
   input  logic                 valid_i,
   input  logic [UW-1:0]        user_i,
   output logic [PW-1:0]        pwr_o,
   output logic                 valid_o,
   output logic [UW-1:0]        user_o
);

   logic signed [2*OW-1:0] re_ext;
   logic signed [2*OW-1:0] im_ext;

   logic [2*OW-1:0] re_sq_d, re_sq_q;
   logic [2*OW-1:0] im_sq_d, im_sq_q;
   logic            sq_vld_d, sq_vld_q;
   logic [UW-1:0]   sq_user_d, sq_user_q;
   logic [PW-1:0]   sum_d, sum_q;
   logic            sum_vld_d, sum_vld_q;
   logic [UW-1:0]   sum_user_d, sum_user_q;

   // Squares are never negative, so they are stored as plain unsigned bits.
   always_comb begin
      re_ext     = {{OW{re_i[OW-1]}}, re_i};
      im_ext     = {{OW{im_i[OW-1]}}, im_i};
      sq_vld_d   = valid_i;
      re_sq_d    = re_sq_q;
      im_sq_d    = im_sq_q;
      sq_user_d  = sq_user_q;
      sum_vld_d  = sq_vld_q;
      sum_d      = sum_q;
      sum_user_d = sum_user_q;
      if (valid_i) begin
         re_sq_d   = re_ext * re_ext;
         im_sq_d   = im_ext * im_ext;
         sq_user_d = user_i;
      end else begin
         sq_user_d = sq_user_q;
      end
      if (sq_vld_q) begin
         sum_d      = PW'(re_sq_q) + PW'(im_sq_q);
         sum_user_d = sq_user_q;
      end else begin
         sum_user_d = sum_user_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         re_sq_q    <= {(2*OW){1'b0}};
         im_sq_q    <= {(2*OW){1'b0}};
         sq_vld_q   <= 1'b0;
         sq_user_q  <= {UW{1'b0}};
         sum_q      <= {PW{1'b0}};
         sum_vld_q  <= 1'b0;
         sum_user_q <= {UW{1'b0}};
      end else begin
         re_sq_q    <= re_sq_d;
         im_sq_q    <= im_sq_d;
         sq_vld_q   <= sq_vld_d;
         sq_user_q  <= sq_user_d;
         sum_q      <= sum_d;
         sum_vld_q  <= sum_vld_d;
         sum_user_q <= sum_user_d;
      end
   end

   assign pwr_o   = sum_q;
   assign valid_o = sum_vld_q;
   assign user_o  = sum_user_q;

endmodule

// File: rtl/sdft_peak_finder.sv
// Per-block peak search over the SDFT bin stream: frames blocks, computes
// bin power, and reports the strongest in-range bin or a framing error.
module sdft_peak_finder
   import sdft_pkg::*;
#(
   parameter int N      = 4048,
   parameter int OW     = 32,
   parameter int AW     = $clog2(N),
   parameter int PW     = pw_of(OW),
   parameter int BIN_LO = 1,
   parameter int BIN_HI = N/2 - 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [2*OW-1:0] data_i,
   input  logic            sob_i,
   input  logic            eob_i,
   input  logic            valid_i,
   output logic [AW-1:0]   peak_bin_o,
   output logic [PW-1:0]   peak_pwr_o,
   output logic            peak_valid_o,
   output logic            frame_err_o
);

   localparam int SBW = $bits(bin_sb_t);
   localparam int UW  = AW + SBW;
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
   localparam logic [AW-1:0] LO_IDX   = AW'(BIN_LO);
   localparam logic [AW-1:0] HI_IDX   = AW'(BIN_HI);

   blk_state_t state_d, state_q;
   logic [AW-1:0] nxt_d, nxt_q;
   logic [AW-1:0] idx;
   logic          accept;
   logic          restart;
   logic          good_end;

   logic            s1_vld_d, s1_vld_q;
   logic [2*OW-1:0] s1_data_d, s1_data_q;
   logic [AW-1:0]   s1_idx_d, s1_idx_q;
   bin_sb_t         s1_sb_d, s1_sb_q;

   logic [PW-1:0] p_pwr;
   logic          p_vld;
   logic [UW-1:0] p_user;
   logic [AW-1:0] p_idx;
   bin_sb_t       p_sb;

   logic          have_d, have_q;
   logic [AW-1:0] best_bin_d, best_bin_q;
   logic [PW-1:0] best_pwr_d, best_pwr_q;
   logic [AW-1:0] peak_bin_d, peak_bin_q;
   logic [PW-1:0] peak_pwr_d, peak_pwr_q;
   logic          peak_valid_d, peak_valid_q;
   logic          frame_err_d, frame_err_q;

   // Block framing: decide per accepted bin its index and its framing outcome.
   always_comb begin
      state_d   = state_q;
      nxt_d     = nxt_q;
      accept    = 1'b0;
      restart   = 1'b0;
      good_end  = 1'b0;
      idx       = nxt_q;
      s1_vld_d  = 1'b0;
      s1_data_d = s1_data_q;
      s1_idx_d  = s1_idx_q;
      s1_sb_d   = {SBW{1'b0}};
      if (valid_i) begin
         case (state_q)
            IDLE: begin
               if (sob_i) begin
                  accept = 1'b1;
                  idx    = {AW{1'b0}};
               end else begin
                  accept = 1'b0;
               end
            end
            OPEN: begin
               accept = 1'b1;
               if (sob_i) begin
                  restart = 1'b1;
                  idx     = {AW{1'b0}};
               end else begin
                  idx = nxt_q;
               end
            end
            default: accept = 1'b0;
         endcase
      end else begin
         accept = 1'b0;
      end
      if (accept) begin
         nxt_d          = idx + AW'(1);
         s1_vld_d       = 1'b1;
         s1_data_d      = data_i;
         s1_idx_d       = idx;
         s1_sb_d.first  = sob_i;
         s1_sb_d.in_rng = (idx >= LO_IDX) && (idx <= HI_IDX);
         good_end       = (idx == LAST_IDX) && !restart;
         if (eob_i) begin
            state_d      = IDLE;
            s1_sb_d.good = good_end;
            s1_sb_d.err  = !good_end;
         end else if (idx == LAST_IDX) begin
            state_d     = IDLE;
            s1_sb_d.err = 1'b1;
         end else begin
            state_d     = OPEN;
            s1_sb_d.err = restart;
         end
      end else begin
         s1_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         nxt_q     <= {AW{1'b0}};
         s1_vld_q  <= 1'b0;
         s1_data_q <= {(2*OW){1'b0}};
         s1_idx_q  <= {AW{1'b0}};
         s1_sb_q   <= {SBW{1'b0}};
      end else begin
         state_q   <= state_d;
         nxt_q     <= nxt_d;
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         s1_idx_q  <= s1_idx_d;
         s1_sb_q   <= s1_sb_d;
      end
   end

   cplx_power #(
      .OW (OW),
      .PW (PW),
      .UW (UW)
   ) u_power (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .re_i    (s1_data_q[OW-1:0]),
      .im_i    (s1_data_q[2*OW-1:OW]),
      .valid_i (s1_vld_q),
      .user_i  ({s1_idx_q, s1_sb_q}),
      .pwr_o   (p_pwr),
      .valid_o (p_vld),
      .user_o  (p_user)
   );

   assign p_idx = p_user[UW-1:SBW];
   assign p_sb  = bin_sb_t'(p_user[SBW-1:0]);

   // Search and result: the end-of-block bin is folded in before reporting.
   always_comb begin
      have_d       = have_q;
      best_bin_d   = best_bin_q;
      best_pwr_d   = best_pwr_q;
      peak_bin_d   = peak_bin_q;
      peak_pwr_d   = peak_pwr_q;
      peak_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (p_vld) begin
         if (p_sb.first) begin
            have_d     = p_sb.in_rng;
            best_bin_d = p_idx;
            best_pwr_d = p_pwr;
         end else if (p_sb.in_rng && (!have_q || (p_pwr > best_pwr_q))) begin
            have_d     = 1'b1;
            best_bin_d = p_idx;
            best_pwr_d = p_pwr;
         end else begin
            have_d = have_q;
         end
         if (p_sb.good) begin
            peak_valid_d = 1'b1;
            peak_bin_d   = best_bin_d;
            peak_pwr_d   = best_pwr_d;
         end else if (p_sb.err) begin
            frame_err_d = 1'b1;
         end else begin
            peak_valid_d = 1'b0;
         end
      end else begin
         have_d = have_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         have_q       <= 1'b0;
         best_bin_q   <= {AW{1'b0}};
         best_pwr_q   <= {PW{1'b0}};
         peak_bin_q   <= {AW{1'b0}};
         peak_pwr_q   <= {PW{1'b0}};
         peak_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         have_q       <= have_d;
         best_bin_q   <= best_bin_d;
         best_pwr_q   <= best_pwr_d;
         peak_bin_q   <= peak_bin_d;
         peak_pwr_q   <= peak_pwr_d;
         peak_valid_q <= peak_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign peak_bin_o   = peak_bin_q;
   assign peak_pwr_o   = peak_pwr_q;
   assign peak_valid_o = peak_valid_q;
   assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_sdft_peak_finder.sv
// Scoreboard bench for sdft_peak_finder: directed blocks push expected
// result/error pulses; a negedge monitor pops and compares them.
module tb_sdft_peak_finder;

   localparam int N      = 16;
   localparam int OW     = 16;
   localparam int AW     = 4;
   localparam int PW     = 32;
   localparam int BIN_LO = 1;
   localparam int BIN_HI = 7;

   logic            clk     = 1'b0;
   logic            rst_i   = 1'b1;
   logic [2*OW-1:0] data_i  = '0;
   logic            sob_i   = 1'b0;
   logic            eob_i   = 1'b0;
   logic            valid_i = 1'b0;
   logic [AW-1:0]   peak_bin_o;
   logic [PW-1:0]   peak_pwr_o;
   logic            peak_valid_o;
   logic            frame_err_o;

   int cyc     = 0;
   int drv_cyc = 0;
   int n_chk   = 0;
   int n_fail  = 0;

   typedef struct {
      bit          is_err;
      logic [63:0] bin;
      logic [63:0] pwr;
      int          at;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   logic signed [15:0] re_v [16];
   logic signed [15:0] im_v [16];

   sdft_peak_finder #(
      .N      (N),
      .OW     (OW),
      .AW     (AW),
      .PW     (PW),
      .BIN_LO (BIN_LO),
      .BIN_HI (BIN_HI)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .data_i       (data_i),
      .sob_i        (sob_i),
      .eob_i        (eob_i),
      .valid_i      (valid_i),
      .peak_bin_o   (peak_bin_o),
      .peak_pwr_o   (peak_pwr_o),
      .peak_valid_o (peak_valid_o),
      .frame_err_o  (frame_err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic signed [15:0] re, input logic signed [15:0] im,
                        input logic sob, input logic eob);
      @(negedge clk);
      data_i  = {im, re};
      sob_i   = sob;
      eob_i   = eob;
      valid_i = 1'b1;
      drv_cyc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_i = 1'b0;
         sob_i   = 1'b0;
         eob_i   = 1'b0;
         data_i  = '0;
      end
   endtask

   task automatic clear_vec();
      for (int i = 0; i < 16; i++) begin
         re_v[i] = 16'sd0;
         im_v[i] = 16'sd0;
      end
   endtask

   // Expected pulse four cycles after the most recently driven bin.
   task automatic expect_ev(input bit is_err, input int bin, input longint pwr);
      exp_t e;
      e.is_err = is_err;
      e.bin    = 64'(bin);
      e.pwr    = 64'(pwr);
      e.at     = drv_cyc + 4;
      exp_q.push_back(e);
   endtask

   task automatic send_bins(input int first, input int last, input bit sob_first,
                            input bit eob_last, input int gap);
      for (int i = first; i <= last; i++) begin
         drive(re_v[i], im_v[i], sob_first && (i == first), eob_last && (i == last));
         if (gap > 0 && i != last) idle(gap);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_i) begin
         if (peak_valid_o || frame_err_o) begin
            chk("pulse_exclusive", 64'(peak_valid_o & frame_err_o), 64'd0);
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL spurious_pulse: valid=%0b err=%0b at cycle %0d, none expected",
                        peak_valid_o, frame_err_o, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pulse_kind_err", 64'(frame_err_o), 64'(mon_e.is_err));
               chk("pulse_cycle", 64'(cyc), 64'(mon_e.at));
               chk("peak_bin", 64'(peak_bin_o), mon_e.bin);
               chk("peak_pwr", 64'(peak_pwr_o), mon_e.pwr);
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_pulse: nothing seen by cycle %0d, required at %0d (err=%0b)",
                     cyc, mon_e.at, mon_e.is_err);
         end
      end
   end

   initial begin
      clear_vec();
      repeat (3) @(negedge clk);
      chk("reset_bin", 64'(peak_bin_o), 64'd0);
      chk("reset_pwr", 64'(peak_pwr_o), 64'd0);
      chk("reset_valid", 64'(peak_valid_o), 64'd0);
      chk("reset_err", 64'(frame_err_o), 64'd0);
      rst_i = 1'b0;
      idle(3);

      // single tone
      clear_vec();
      re_v[3] = 16'sd1000;
      send_bins(0, 15, 1'b1, 1'b1, 0);
      expect_ev(1'b0, 3, 64'd1000000);
      idle(8);

      // tie keeps lowest index; valid gaps between bins
      clear_vec();
      re_v[2] = 16'sd300;  im_v[2] = -16'sd400;
      re_v[5] = 16'sd300;  im_v[5] = -16'sd400;
      send_bins(0, 15, 1'b1, 1'b1, 1);
      expect_ev(1'b0, 2, 64'd250000);
      idle(8);

      // out-of-range bins are ignored
      clear_vec();
      re_v[0]  = 16'sd20000;
      re_v[12] = 16'sd20000; im_v[12] = 16'sd20000;
      re_v[4]  = 16'sd5;     im_v[4]  = 16'sd5;
      send_bins(0, 15, 1'b1, 1'b1, 0);
      expect_ev(1'b0, 4, 64'd50);
      idle(8);

      // extremes, then back-to-back block
      clear_vec();
      re_v[1] = -16'sd32768; im_v[1] = -16'sd32768;
      send_bins(0, 15, 1'b1, 1'b1, 0);
      expect_ev(1'b0, 1, 64'd2147483648);
      clear_vec();
      re_v[7] = 16'sd1;
      send_bins(0, 15, 1'b1, 1'b1, 0);
      expect_ev(1'b0, 7, 64'd1);
      idle(8);

      // early eob at count 10: error, outputs keep last result
      clear_vec();
      re_v[3] = 16'sd9;
      send_bins(0, 10, 1'b1, 1'b1, 0);
      expect_ev(1'b1, 7, 64'd1);
      idle(8);

      // count reaches N-1 without eob, then stray bins while idle
      send_bins(0, 15, 1'b1, 1'b0, 0);
      expect_ev(1'b1, 7, 64'd1);
      drive(16'sd100, 16'sd0, 1'b0, 1'b1);
      drive(16'sd100, 16'sd0, 1'b0, 1'b0);
      drive(16'sd100, 16'sd0, 1'b0, 1'b1);
      idle(8);

      // premature restart at count 5, restarted block reports
      clear_vec();
      re_v[3] = 16'sd30000;
      send_bins(0, 4, 1'b1, 1'b0, 0);
      clear_vec();
      im_v[6] = 16'sd700;
      drive(16'sd0, 16'sd0, 1'b1, 1'b0);
      expect_ev(1'b1, 7, 64'd1);
      send_bins(1, 15, 1'b0, 1'b1, 0);
      expect_ev(1'b0, 6, 64'd490000);
      idle(8);

      // reset mid-block clears outputs immediately
      clear_vec();
      re_v[2] = 16'sd50;
      send_bins(0, 8, 1'b1, 1'b0, 0);
      @(negedge clk);
      valid_i = 1'b0;
      sob_i   = 1'b0;
      eob_i   = 1'b0;
      rst_i   = 1'b1;
      #1;
      chk("midrst_bin", 64'(peak_bin_o), 64'd0);
      chk("midrst_pwr", 64'(peak_pwr_o), 64'd0);
      chk("midrst_valid", 64'(peak_valid_o), 64'd0);
      chk("midrst_err", 64'(frame_err_o), 64'd0);
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      idle(6);
      clear_vec();
      re_v[5] = -16'sd3; im_v[5] = 16'sd4;
      send_bins(0, 15, 1'b1, 1'b1, 0);
      expect_ev(1'b0, 5, 64'd25);
      idle(8);

      for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expected pulses still pending", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sdft_peak_finder.md
# sdft_peak_finder

Streaming consumer placed directly after the sliding-DFT core. It takes the per-sample block of N complex bins (start/end-of-block framed), computes each bin's power |X|² = re² + im² in a short pipeline, and tracks the strongest bin inside a configurable search range. Once per block it reports the winning bin index and its power. Malformed blocks are flagged and produce no result.

## Interface
- `N`, 4048, bins per block; must match the upstream SDFT.
- `OW`, 32, width of each signed real/imag component.
- `AW`, `$clog2(N)`, bin index width.
- `PW`, `2*OW`, unsigned power width.
- `BIN_LO`, 1, first bin searched (inclusive).
- `BIN_HI`, N/2-1, last bin searched (inclusive); requires 0 ≤ BIN_LO ≤ BIN_HI ≤ N-1.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `data_i`  in  2*OW  bin value; `{im, re}`, each signed OW bits.
- `sob_i`  in  1  start of block; qualified by `valid_i`, marks bin 0.
- `eob_i`  in  1  end of block; qualified by `valid_i`, marks bin N-1.
- `valid_i`  in  1  `data_i` carries a bin this cycle.
- `peak_bin_o`  out  AW  index of the strongest in-range bin.
- `peak_pwr_o`  out  PW  power of that bin.
- `peak_valid_o`  out  1  one-cycle pulse when a new result is presented.
- `frame_err_o`  out  1  one-cycle pulse for a malformed block.

## Operation
- **Bin counter:**
  - Loaded to 0 on `valid_i & sob_i`.
  - Increments on every other `valid_i` while a block is open.
  - Gaps in `valid_i` are allowed; the counter and pipeline hold.
- **Block state:**
  - `IDLE`: `valid_i & sob_i` goes to `OPEN`. Any other `valid_i` is ignored, and no error is raised.
  - `OPEN`:
    - `valid_i & sob_i` is a premature restart: pulse `frame_err_o`, discard the partial block, and stay `OPEN` with a fresh search starting at bin 0.
    - `valid_i & eob_i` with count == N-1 ends a good block and returns to `IDLE`.
    - `valid_i & eob_i` with count ≠ N-1 is an error block: pulse `frame_err_o`, emit no result, return to `IDLE`.
    - Count reaching N-1 without `eob_i` is an error: pulse `frame_err_o`, return to `IDLE`.
  - `sob_i & eob_i` in the same valid cycle counts as an error only when N > 1.
- **Power arithmetic:**
  - re² and im² are signed OW×OW products, each of width 2*OW.
  - Their sum is unsigned PW bits and cannot overflow: the maximum is 2·(2^(OW-1))² = 2^(2*OW-1), so no saturation logic is needed.
- **Search:**
  - The first in-range bin of a block loads the best register unconditionally.
  - Each later in-range bin replaces the best only if its power is strictly greater, so ties keep the lowest index.
  - Out-of-range bins never affect the result.
- **Result:**
  - On a good end of block, `peak_bin_o`/`peak_pwr_o` take the best values and `peak_valid_o` pulses.
  - Both outputs hold until the next result.
  - `frame_err_o` and `peak_valid_o` are never high in the same cycle.

## Timing
- **Reset:** all outputs, state (`IDLE`), counter, pipeline valids and best registers go to 0 immediately on `rst_i`. An in-flight block is discarded with no error pulse.
- **Pipeline:**
  - S1 registers input, bin index and framing.
  - S2 registers the two squares.
  - S3 registers the sum.
  - The compare/update happens on the S3 output.
- **Result latency:** `valid_i & eob_i` at cycle t gives `peak_valid_o` at t+4, with outputs updated in the same cycle. Throughput is one bin per clock.
- **Error latency:** `frame_err_o` uses the same latency, t+4 from the offending input.
- **Back-to-back blocks:** a new `sob_i` at t+1 after `eob_i` at t is accepted. The best register of the new block is initialised independently of the result still draining, so there is no bubble.

## Structure
- Shared package `sdft_pkg` holds:
  - the complex sample typedef (`struct packed {logic signed [OW-1:0] im, re;}`);
  - the framing/state enum (`IDLE`, `OPEN`);
  - a `pw_of(OW)` width constant function.
- Sub-module `cplx_power` implements the two-stage square-and-sum pipeline (S2–S3) with a valid sideband. It is reusable by later magnitude-based stages.

## Test plan
Bench parameters: N=16, OW=16, BIN_LO=1, BIN_HI=7.

1. **Single tone:** bin 3 = (re 1000, im 0), all other bins 0 → `peak_bin_o`=3, `peak_pwr_o`=1000000, pulse exactly 4 cycles after `eob_i`.
2. **Tie:** bins 2 and 5 both (300, -400) → bin 2, power 250000.
3. **Out-of-range:** bin 0 = (20000, 0), bin 12 = (20000, 20000), bin 4 = (5, 5) → bin 4, power 50.
4. **Extremes:** bin 1 = (-32768, -32768) → power 2147483648, no overflow. Back-to-back second block with bin 7 = (1, 0) and the rest 0 → bin 7, power 1.
5. **Framing:**
   - `eob_i` at count 10 → `frame_err_o` pulse at t+4, no `peak_valid_o`, outputs unchanged.
   - `sob_i` at count 5 → error pulse, then the restarted block reports correctly.
6. **Reset mid-block:** assert `rst_i` at count 8 → all outputs 0 at once. A full block after release reports correctly, with no spurious pulses.
